dmem_responder: RTL and testbench

//   Data-memory responder for the CPU load/store port. It accepts one word

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int WORD_BYTES = 4;

   // Misaligned or beyond the last word of the array.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
      logic [31:0] limit;
      limit = 32'(WORD_BYTES * depth);
      return (addr[1:0] != 2'b00) || (addr >= limit);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: write on posedge, read data registered at the same edge.
module dmem_array #(
   parameter int DEPTH_WORDS = 64,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[idx] <= wdata;
      end
      rdata_q <= mem_q[idx];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one outstanding word request, fixed access latency,
// response held until taken.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | counting down the access latency
// RESP  | response presented, waiting for resp_ready
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = $clog2(LATENCY + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q, write_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             req_ready_q, req_ready_d;
   logic             resp_valid_q, resp_valid_d;
   logic             resp_err_q, resp_err_d;
   logic             rd_sel_q, rd_sel_d;
   logic             err;
   logic             we;
   logic [31:0]      arr_rdata;

   assign err = addr_err(addr_q, DEPTH_WORDS);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      rd_sel_d     = rd_sel_q;
      we           = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d     = req_write;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               cnt_d       = CNT_W'(LATENCY - 1);
               req_ready_d = 1'b0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               // Access commits here; a reset before this edge leaves the array untouched.
               we           = write_q && !err;
               resp_valid_d = 1'b1;
               resp_err_d   = err;
               rd_sel_d     = !write_q && !err;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               rd_sel_d     = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d      = IDLE;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b0;
            resp_err_d   = 1'b0;
            rd_sel_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rd_sel_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         rd_sel_q     <= rd_sel_d;
      end
   end

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk  (clk),
      .we   (we),
      .idx  (addr_q[IDX_W+1:2]),
      .wdata(wdata_q),
      .rdata(arr_rdata)
   );

   // The array keeps reading the latched index, which cannot change while in RESP.
   assign resp_rdata = rd_sel_q ? arr_rdata : 32'h0;
   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (latency 2, 1, 3) checked
// every cycle against a request/response model plus literal expectations.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_write [3];
   logic [31:0] req_addr [3];
   logic [31:0] req_wdata [3];
   logic        resp_valid [3];
   logic        resp_ready [3];
   logic [31:0] resp_rdata [3];
   logic        resp_err [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      dmem_responder #(
         .DEPTH_WORDS(64),
         .LATENCY    ((k == 0) ? 2 : ((k == 1) ? 1 : 3))
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req_valid (req_valid[k]),
         .req_ready (req_ready[k]),
         .req_write (req_write[k]),
         .req_addr  (req_addr[k]),
         .req_wdata (req_wdata[k]),
         .resp_valid(resp_valid[k]),
         .resp_ready(resp_ready[k]),
         .resp_rdata(resp_rdata[k]),
         .resp_err  (resp_err[k])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: request waits lat_of(k) edges, then responds until taken.
   bit          m_idle [3];
   int          m_cnt [3];
   bit          m_resp [3];
   bit          m_w [3];
   logic [31:0] m_a [3];
   logic [31:0] m_d [3];
   logic [31:0] m_rdata [3];
   bit          m_err [3];
   bit          m_known [3];
   logic [31:0] mem [3][64];
   bit          mem_v [3][64];
   int          wi;

   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            m_idle[k] = 1'b1;
            m_cnt[k]  = 0;
            m_resp[k] = 1'b0;
         end else if (m_idle[k]) begin
            if (req_valid[k]) begin
               m_idle[k] = 1'b0;
               m_cnt[k]  = lat_of(k);
               m_w[k]    = req_write[k];
               m_a[k]    = req_addr[k];
               m_d[k]    = req_wdata[k];
            end
         end else if (m_cnt[k] > 0) begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
               m_err[k]   = (m_a[k] % 4 != 0) || (m_a[k] >= 32'd256);
               m_rdata[k] = 32'h0;
               m_known[k] = 1'b1;
               if (!m_err[k]) begin
                  wi = int'(m_a[k] >> 2);
                  if (m_w[k]) begin
                     mem[k][wi]   = m_d[k];
                     mem_v[k][wi] = 1'b1;
                  end else begin
                     m_rdata[k] = mem[k][wi];
                     m_known[k] = mem_v[k][wi];
                  end
               end
               m_resp[k] = 1'b1;
            end
         end else if (m_resp[k] && resp_ready[k]) begin
            m_resp[k] = 1'b0;
            m_idle[k] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("req_ready[%0d]", k), req_ready[k], m_idle[k]);
            chk($sformatf("resp_valid[%0d]", k), resp_valid[k], m_resp[k]);
            chk($sformatf("resp_err[%0d]", k), resp_err[k], m_resp[k] ? m_err[k] : 1'b0);
            if (!m_resp[k] || m_known[k])
               chk($sformatf("resp_rdata[%0d]", k), resp_rdata[k], m_resp[k] ? m_rdata[k] : 32'h0);
         end
      end
   end

   // Issue one request; lat counts edges from accept to resp_valid.
   task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int hold, output int lat, output logic [31:0] rd, output logic er);
      @(negedge clk);
      req_valid[k]  = 1'b1;
      req_write[k]  = w;
      req_addr[k]   = a;
      req_wdata[k]  = d;
      resp_ready[k] = (hold == 0);
      @(negedge clk);
      req_valid[k] = 1'b0;
      lat = 0;
      while (resp_valid[k] !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = resp_rdata[k];
      er = resp_err[k];
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
               req_valid[k] = 1'b1;
               req_write[k] = 1'b0;
               req_addr[k]  = 32'h4;
            end
            if (i == 3) req_valid[k] = 1'b0;
            @(negedge clk);
            chk("hold_resp_valid", resp_valid[k], 1'b1);
            chk("hold_req_ready", req_ready[k], 1'b0);
         end
         resp_ready[k] = 1'b1;
      end
      @(posedge clk);
   endtask

   int          lat;
   logic [31:0] rd;
   logic        er;

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         req_valid[k]  = 1'b0;
         req_write[k]  = 1'b0;
         req_addr[k]   = 32'h0;
         req_wdata[k]  = 32'h0;
         resp_ready[k] = 1'b0;
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", req_ready[0], 1'b1);
      chk("rst_resp_valid", resp_valid[0], 1'b0);
      chk("rst_resp_err", resp_err[0], 1'b0);
      chk("rst_resp_rdata", resp_rdata[0], 32'h0);

      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, lat, rd, er);
      chk("store_latency", lat, 2);
      chk("store_err", er, 1'b0);
      chk("store_rdata", rd, 32'h0);
      do_req(0, 1'b0, 32'h10, 32'h0, 0, lat, rd, er);
      chk("load_latency", lat, 2);
      chk("load_rdata", rd, 32'hDEADBEEF);

      do_req(0, 1'b1, 32'h0, 32'h0BAD0000, 0, lat, rd, er);
      do_req(0, 1'b0, 32'h13, 32'h0, 0, lat, rd, er);
      chk("misaligned_err", er, 1'b1);
      chk("misaligned_rdata", rd, 32'h0);
      do_req(0, 1'b0, 32'h100, 32'h0, 0, lat, rd, er);
      chk("range_err", er, 1'b1);
      chk("range_rdata", rd, 32'h0);
      do_req(0, 1'b1, 32'h102, 32'hFFFFFFFF, 0, lat, rd, er);
      chk("bad_store_err", er, 1'b1);
      do_req(0, 1'b0, 32'h0, 32'h0, 0, lat, rd, er);
      chk("word0_kept", rd, 32'h0BAD0000);
      do_req(0, 1'b0, 32'h10, 32'h0, 0, lat, rd, er);
      chk("word4_kept", rd, 32'hDEADBEEF);

      do_req(0, 1'b0, 32'h10, 32'h0, 5, lat, rd, er);
      chk("held_rdata", rd, 32'hDEADBEEF);
      do_req(0, 1'b0, 32'h0, 32'h0, 0, lat, rd, er);
      chk("after_hold_rdata", rd, 32'h0BAD0000);

      do_req(0, 1'b1, 32'h8, 32'hA5A50001, 0, lat, rd, er);
      @(negedge clk);
      req_valid[0]  = 1'b1;
      req_write[0]  = 1'b1;
      req_addr[0]   = 32'h8;
      req_wdata[0]  = 32'h12345678;
      resp_ready[0] = 1'b0;
      @(negedge clk);
      req_valid[0] = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("midrst_req_ready", req_ready[0], 1'b1);
      chk("midrst_resp_valid", resp_valid[0], 1'b0);
      chk("midrst_resp_err", resp_err[0], 1'b0);
      chk("midrst_resp_rdata", resp_rdata[0], 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      do_req(0, 1'b0, 32'h8, 32'h0, 0, lat, rd, er);
      chk("midrst_word_kept", rd, 32'hA5A50001);

      for (int k = 1; k < 3; k++) begin
         for (int i = 0; i < 8; i++) begin
            do_req(k, 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(k * 256 + i), 0, lat, rd, er);
            chk($sformatf("b2b_store_lat[%0d][%0d]", k, i), lat, (k == 1) ? 1 : 3);
         end
         for (int i = 0; i < 8; i++) begin
            do_req(k, 1'b0, 32'(i * 4), 32'h0, 0, lat, rd, er);
            chk($sformatf("b2b_load_lat[%0d][%0d]", k, i), lat, (k == 1) ? 1 : 3);
            chk($sformatf("b2b_load_rdata[%0d][%0d]", k, i), rd, 32'hC0DE0000 + 32'(k * 256 + i));
         end
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
